// File: rtl/memtest_pkg.sv
// Shared definitions for the SRAM memory-test sequencer: state/pattern encodings,
// LFSR taps and the per-address test word.
package memtest_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWr     = 3'd1,
        StRdReq  = 3'd2,
        StRdWait = 3'd3,
        StDone   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PatAddr    = 2'd0,
        PatWalk    = 2'd1,
        PatLfsr    = 2'd2,
        PatInvAddr = 2'd3
    } pattern_e;

    localparam logic [15:0] LfsrDefaultSeed = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
    localparam logic [15:0] LfsrTaps = 16'h002D;

    function automatic logic [15:0] pattern_word(input pattern_e pat, input logic [15:0] addr16,
                                                 input logic [15:0] lfsr);
        logic [15:0] word;
        unique case (pat)
            PatAddr:    word = addr16;
            PatWalk:    word = 16'h0001 << addr16[3:0];
            PatLfsr:    word = lfsr;
            PatInvAddr: word = ~addr16;
            default:    word = addr16;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/memtest_lfsr.sv
// 16-bit Fibonacci LFSR used as the pseudo-random data source; load wins over step.
module memtest_lfsr
    import memtest_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] value_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= seed;
        end else if (step) begin
            value_q <= {^(value_q & LfsrTaps), value_q[15:1]};
        end
    end

    assign value = value_q;

endmodule

// File: rtl/sram_memtest_seq.sv
// SRAM test sequencer: writes a pattern over an address range, reads it back and
// records the mismatch count plus the first failing location.
module sram_memtest_seq
    import memtest_pkg::*;
#(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16
) (
    input  logic              input_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_start_addr,
    input  logic [ADDR_W-1:0] cfg_end_addr,
    input  logic [1:0]        cfg_pattern,
    input  logic [15:0]       cfg_seed,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              cfg_err,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, start_addr_q, end_addr_q, fail_addr_q;
    pattern_e            pattern_q;
    logic [15:0]         seed_q, err_count_q, err_count_d;
    logic [DATA_W-1:0]   fail_exp_q, fail_got_q;
    logic                cfg_err_q, cfg_err_d, aborted_q, aborted_d, abort_pend_q, abort_pend_d;
    logic                launch, fail_capture, lfsr_load, lfsr_step, at_end;
    logic [15:0]         lfsr_seed, lfsr_value, launch_seed, expected, addr16;

    assign launch_seed = (cfg_seed == 16'h0000) ? LfsrDefaultSeed : cfg_seed;
    assign at_end      = (addr_q == end_addr_q);
    assign addr16      = 16'(addr_q);
    assign expected    = pattern_word(pattern_q, addr16, lfsr_value);

    memtest_lfsr u_lfsr (
        .clk   (input_clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (lfsr_seed),
        .value (lfsr_value)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        err_count_d  = err_count_q;
        cfg_err_d    = cfg_err_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;
        launch       = 1'b0;
        fail_capture = 1'b0;
        lfsr_load    = 1'b0;
        lfsr_step    = 1'b0;
        lfsr_seed    = seed_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    launch       = 1'b1;
                    lfsr_load    = 1'b1;
                    lfsr_seed    = launch_seed;
                    addr_d       = cfg_start_addr;
                    err_count_d  = '0;
                    aborted_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    cfg_err_d    = (cfg_end_addr < cfg_start_addr);
                    state_d      = cfg_err_d ? StDone : StWr;
                end
            end
            StWr: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    if (at_end) begin
                        addr_d    = start_addr_q;
                        lfsr_load = 1'b1;
                        state_d   = StRdReq;
                    end else begin
                        addr_d    = addr_q + 1'b1;
                        lfsr_step = 1'b1;
                    end
                end
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StRdReq: begin
                mem_req = 1'b1;
                // An accepted read must still be drained, so abort is deferred to RD_WAIT.
                if (mem_ready) begin
                    state_d      = StRdWait;
                    abort_pend_d = abort;
                end else if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StRdWait: begin
                if (abort) abort_pend_d = 1'b1;
                if (mem_rvalid) begin
                    if (abort || abort_pend_q) begin
                        aborted_d = 1'b1;
                        state_d   = StDone;
                    end else begin
                        if (mem_rdata != expected) begin
                            err_count_d  = (err_count_q == 16'hFFFF) ? err_count_q
                                                                     : err_count_q + 16'd1;
                            fail_capture = (err_count_q == 16'h0000);
                        end
                        if (at_end) begin
                            state_d = StDone;
                        end else begin
                            addr_d    = addr_q + 1'b1;
                            lfsr_step = 1'b1;
                            state_d   = StRdReq;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge input_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            pattern_q    <= PatAddr;
            seed_q       <= '0;
            err_count_q  <= '0;
            cfg_err_q    <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            fail_addr_q  <= '0;
            fail_exp_q   <= '0;
            fail_got_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            err_count_q  <= err_count_d;
            cfg_err_q    <= cfg_err_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
            if (launch) begin
                start_addr_q <= cfg_start_addr;
                end_addr_q   <= cfg_end_addr;
                pattern_q    <= pattern_e'(cfg_pattern);
                seed_q       <= launch_seed;
                fail_addr_q  <= '0;
                fail_exp_q   <= '0;
                fail_got_q   <= '0;
            end else if (fail_capture) begin
                fail_addr_q <= addr_q;
                fail_exp_q  <= expected;
                fail_got_q  <= mem_rdata;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = (state_q == StWr) ? expected : '0;
    assign busy      = (state_q == StWr) || (state_q == StRdReq) || (state_q == StRdWait);
    assign done      = (state_q == StDone);
    assign pass      = done && (err_count_q == 16'h0000) && !cfg_err_q && !aborted_q;
    assign cfg_err   = cfg_err_q;
    assign err_count = err_count_q;
    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_got  = fail_got_q;

endmodule

// File: doc/sram_memtest_seq.md
SRAM_MEMTEST_SEQ -- requirements
Module: sram_memtest_seq

Interface
REQ-001 Parameters: ADDR_W, default 18, SRAM word-address width; DATA_W, fixed at 16, SRAM data width.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low. input_clk is the block clock; rst_n is the reset.
REQ-003 input_clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle pulse that launches a test.
REQ-006 abort  in  1  level; ends the test in progress.
REQ-007 cfg_start_addr  in  ADDR_W  first tested address.
REQ-008 cfg_end_addr  in  ADDR_W  last tested address, inclusive.
REQ-009 cfg_pattern  in  2  0=addr, 1=walking-one, 2=LFSR, 3=~addr.
REQ-010 cfg_seed  in  16  LFSR seed; 0 is replaced by 16'hACE1.
REQ-011 mem_req  out  1  transaction request.
REQ-012 mem_we  out  1  1=write, 0=read.
REQ-013 mem_addr  out  ADDR_W  transaction address.
REQ-014 mem_wdata  out  16  write data.
REQ-015 mem_ready  in  1  request accepted this cycle.
REQ-016 mem_rvalid  in  1  read data valid.
REQ-017 mem_rdata  in  16  read data.
REQ-018 busy, done, pass, cfg_err  out  1 each  status outputs.
REQ-019 err_count  out  16  saturating mismatch count.
REQ-020 fail_addr, fail_exp, fail_got  out  ADDR_W/16/16  first mismatch record.

Function
REQ-021 States: IDLE, WR, RD_REQ, RD_WAIT, DONE.
REQ-022 Reset or IDLE: mem_req=0; busy=0.
REQ-023 start in IDLE or DONE: latch all cfg_* inputs; clear done, pass, cfg_err, err_count and fail_*; load addr=start; load LFSR with the seed; set busy=1; enter WR on the next cycle.
REQ-024 start is ignored while busy=1.
REQ-025 cfg_end_addr < cfg_start_addr at start: enter DONE on the next cycle; cfg_err=1; pass=0; no memory access occurs.
REQ-026 WR: mem_req=1 and mem_we=1; mem_addr and mem_wdata are held stable until mem_ready.
REQ-027 mem_ready in WR: if addr==end, reload addr=start, re-seed the LFSR and enter RD_REQ; otherwise increment addr, advance the LFSR and remain in WR.
REQ-028 WR issues at most one write per cycle.
REQ-029 Address comparison precedes increment, so end = all-ones never wraps.
REQ-030 RD_REQ: mem_req=1 and mem_we=0; on mem_ready, enter RD_WAIT.
REQ-031 RD_WAIT: mem_req=0; exactly one read is outstanding.
REQ-032 On mem_rvalid in RD_WAIT, compare mem_rdata with the expected pattern for addr.
REQ-033 Mismatch: err_count += 1, saturating at 16'hFFFF; on the first mismatch only, capture fail_addr, fail_exp and fail_got.
REQ-034 After the compare: if addr==end, enter DONE; otherwise increment addr, advance the LFSR and enter RD_REQ.
REQ-035 Patterns are functions of addr only: 0 = addr zero-extended or truncated to 16 bits; 1 = 1<<addr[3:0]; 3 = bitwise inverse of pattern 0.
REQ-036 Pattern 2 is a Fibonacci LFSR x^16+x^14+x^13+x^11+1, advanced once per address, giving an identical sequence in the write and read passes.
REQ-037 DONE: busy=0; done=1; pass=(err_count==0 && !cfg_err); outputs hold until the next start.
REQ-038 abort while busy in WR or RD_REQ: drop mem_req on the next cycle; enter DONE with pass=0.
REQ-039 abort in RD_WAIT: wait for mem_rvalid, discard the data, then enter DONE with pass=0.
REQ-040 Latency: start to first mem_req is 1 cycle; final rvalid to done is 1 cycle.
REQ-041 mem_rvalid is ignored outside RD_WAIT.

Reset
REQ-042 rst_n low asynchronously forces IDLE and clears every output and internal register to 0.
REQ-043 Reset applied mid-transaction abandons the transaction with no completion handshake.
REQ-044 Deassertion of rst_n is synchronised externally.

Structure
REQ-045 The state encodings, pattern codes, LFSR taps and default seed belong in a shared package, memtest_pkg.
REQ-046 The LFSR is the one natural sub-module, memtest_lfsr, with load, step, seed and value ports.

Verification
REQ-047 Range 0..7, pattern 0, zero-latency ideal memory -> 8 writes of data 0..7, then 8 reads; done=1, pass=1, err_count=0.
REQ-048 Memory model corrupts addr 5 bit 3, pattern 3 -> err_count=1, fail_addr=5, fail_exp=16'hFFFA, fail_got=16'hFFF2, pass=0.
REQ-049 start=10, end=3 -> done 1 cycle later, cfg_err=1, mem_req never asserted.
REQ-050 end=all-ones, start=all-ones-2, pattern 2, seed 0 -> 3 writes, then 3 reads matching the 16'hACE1 sequence, with no address wrap.
REQ-051 mem_ready delayed 3 cycles, abort raised in RD_WAIT -> rvalid is consumed, then DONE with pass=0; a start pulse during the test is ignored.
REQ-052 rst_n low during WR -> all outputs 0 asynchronously; a fresh start afterwards runs normally.
